// File: rtl/imem_ctrl_pkg.sv
// Shared types for the instruction-memory access controller: FSM state
// encoding, the queued debug request record and the address range helper.
package imem_ctrl_pkg;

  localparam int IMEM_AW_DEF = 14;
  localparam int REQ_W       = 65;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DBG    = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  // {we, addr, wdata} -- 1 + 32 + 32 = REQ_W bits
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbg_req_t;

  // A byte address reaches imem only if no bit above the word-address field is set
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/dbg_req_fifo.sv
// Synchronous FIFO holding debug loader requests until the controller is
// halted. Occupancy counter gives full/empty; pointers wrap naturally since
// DEPTH is a power of two.
module dbg_req_fifo
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards everything queued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the IF-stage imem port between fetch and a debug loader. The
// pipeline is halted (RUN -> DRAIN -> DBG), queued debug accesses are
// serviced one per cycle, then fetch restarts at the held pc via RESUME.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int IMEM_AW    = IMEM_AW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        halt_req,
  output logic        fetch_stall,
  output logic        halted,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_we,
  input  logic [31:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_rdata,
  output logic        dbg_rsp_err,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_din,
  input  logic [31:0] imem_dout
);

  state_t      state_q;
  state_t      state_d;
  dbg_req_t    req_in;
  dbg_req_t    head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        req_push;
  logic        req_pop;
  logic        head_in_range;
  logic        unused_addr_lsb;

  logic        vld_p1;
  logic [31:0] rdata_p1;
  logic        err_p1;

  assign req_in        = '{we: dbg_req_we, addr: dbg_req_addr, wdata: dbg_req_wdata};
  assign dbg_req_ready = ~fifo_full;
  assign req_push      = dbg_req_valid & ~fifo_full;
  assign req_pop       = (state_q == ST_DBG) & ~fifo_empty;
  assign head_in_range = addr_in_range(head.addr, IMEM_AW);
  assign unused_addr_lsb = ^head.addr[1:0];

  dbg_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .wdata (req_in),
    .pop   (req_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and imem port mux; fetch owns the port unless a request is issued in DBG
  always_comb begin
    state_d     = state_q;
    fetch_stall = 1'b1;
    halted      = 1'b0;
    imem_addr   = pc;
    imem_we     = 1'b0;
    imem_din    = '0;
    case (state_q)
      ST_RUN: begin
        fetch_stall = 1'b0;
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DBG;
      end
      ST_DBG: begin
        halted = 1'b1;
        if (!fifo_empty) begin
          imem_addr = {head.addr[31:2], 2'b00};
          imem_we   = head.we & head_in_range;
          imem_din  = head.wdata;
        end else if (!halt_req) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stage p1: response register, captures read data at issue (zero for writes and errors)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= req_pop;
      err_p1   <= req_pop & ~head_in_range;
      rdata_p1 <= (req_pop & ~head.we & head_in_range) ? imem_dout : '0;
    end
  end

  assign dbg_rsp_valid = vld_p1;
  assign dbg_rsp_rdata = rdata_p1;
  assign dbg_rsp_err   = err_p1;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed halt/resume sequences plus randomized
// debug traffic, with a reference memory and an expected-response queue.
module tb_imem_access_ctrl;

  localparam int MEM_WORDS = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        halt_req;
  logic        fetch_stall;
  logic        halted;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [31:0] dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_rdata;
  logic        dbg_rsp_err;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_din;
  logic [31:0] imem_dout;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        init_mem;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  imem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .halt_req      (halt_req),
    .fetch_stall   (fetch_stall),
    .halted        (halted),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_we    (dbg_req_we),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .dbg_rsp_err   (dbg_rsp_err),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_din      (imem_din),
    .imem_dout     (imem_dout)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = 32'(i);
    return (v * 32'h0001_0101) ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: combinational read, write on clock edge
  assign imem_dout = mem[imem_addr[15:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
    end else if (imem_we) begin
      mem[imem_addr[15:2]] <= imem_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one accepted request, in queue order
  task automatic model_accept(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    rsp_t r;
    int   idx;
    idx = int'(addr / 4) % MEM_WORDS;
    if (addr >= 32'h0001_0000) begin
      r.rdata = 32'h0; r.err = 1'b1;
    end else if (we) begin
      ref_mem[idx] = wd;
      r.rdata = 32'h0; r.err = 1'b0;
    end else begin
      r.rdata = ref_mem[idx]; r.err = 1'b0;
    end
    exp_q.push_back(r);
  endtask

  // Offer one request until accepted; asks for a halt if it sits blocked too long
  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic rdy;
    int   n;
    dbg_req_valid = 1'b1;
    dbg_req_we    = we;
    dbg_req_addr  = addr;
    dbg_req_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = dbg_req_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(we, addr, wd);
        break;
      end
      n++;
      if (n == 20) halt_req = 1'b1;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL push_timeout: request %h not accepted within 200 cycles", addr);
        break;
      end
    end
    #1;
    dbg_req_valid = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (fetch_stall !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("reach_run", 32'(fetch_stall), 32'h0);
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: response scoreboard plus port-ownership invariants
  always @(negedge clk) begin
    if (dbg_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: got rdata %h err %b, expected no response", dbg_rsp_rdata, dbg_rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", dbg_rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(dbg_rsp_err), 32'(mon_e.err));
      end
    end
    if (imem_we === 1'b1) chk("we_only_in_dbg", 32'(halted), 32'h1);
    if (fetch_stall === 1'b0) chk("run_addr_is_pc", imem_addr, pc);
  end

  initial begin
    rst = 1'b1; init_mem = 1'b1; pc = 32'h40; halt_req = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    step(); init_mem = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // 1: reset state
    chk("rst_imem_addr", imem_addr, 32'h40);
    chk("rst_stall", 32'(fetch_stall), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_ready", 32'(dbg_req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'h0);

    // 2: write then read back through the halt sequence
    push(1'b1, 32'h10, 32'hDEAD_BEEF);
    push(1'b0, 32'h13, 32'h0);
    chk("t2_still_run", 32'(fetch_stall), 32'h0);
    halt_req = 1'b1;
    step();
    chk("t2_drain_stall", 32'(fetch_stall), 32'h1);
    chk("t2_drain_halted", 32'(halted), 32'h0);
    chk("t2_drain_we", 32'(imem_we), 32'h0);
    chk("t2_drain_addr", imem_addr, pc);
    step();
    chk("t2_dbg_halted", 32'(halted), 32'h1);
    chk("t2_wr_we", 32'(imem_we), 32'h1);
    chk("t2_wr_addr", imem_addr, 32'h10);
    chk("t2_wr_din", imem_din, 32'hDEAD_BEEF);
    step();
    chk("t2_rd_we", 32'(imem_we), 32'h0);
    chk("t2_rd_addr", imem_addr, 32'h10);
    step();
    chk("t2_idle_addr", imem_addr, pc);
    chk("t2_idle_halted", 32'(halted), 32'h1);

    // 3: out-of-range write is suppressed
    push(1'b1, 32'h0001_0000, 32'h1234_5678);
    chk("t3_err_we", 32'(imem_we), 32'h0);
    chk("t3_err_addr", imem_addr, 32'h0001_0000);
    push(1'b0, 32'h0, 32'h0);
    wait_drained();

    // 4: fill the FIFO in RUN, fifth request waits for service
    halt_req = 1'b0;
    wait_run();
    for (int i = 0; i < 4; i++) push(i[0], 32'h100 + 32'(i) * 4, 32'hC000_0000 + 32'(i));
    chk("t4_full_ready", 32'(dbg_req_ready), 32'h0);
    chk("t4_still_run", 32'(fetch_stall), 32'h0);
    halt_req = 1'b1;
    push(1'b0, 32'h104, 32'h0);
    wait_drained();

    // 5: halt dropped with two queued, then re-halt during RESUME
    halt_req = 1'b0;
    wait_run();
    push(1'b1, 32'h200, 32'h5555_AAAA);
    push(1'b0, 32'h200, 32'h0);
    halt_req = 1'b1;
    step();
    chk("t5_drain_stall", 32'(fetch_stall), 32'h1);
    halt_req = 1'b0;
    step();
    chk("t5_pop1_halted", 32'(halted), 32'h1);
    chk("t5_pop1_we", 32'(imem_we), 32'h1);
    step();
    chk("t5_pop2_halted", 32'(halted), 32'h1);
    step();
    chk("t5_idle_halted", 32'(halted), 32'h1);
    step();
    chk("t5_resume_stall", 32'(fetch_stall), 32'h1);
    chk("t5_resume_halted", 32'(halted), 32'h0);
    halt_req = 1'b1;
    step();
    chk("t5_run_stall", 32'(fetch_stall), 32'h0);
    step();
    chk("t5_redrain_stall", 32'(fetch_stall), 32'h1);
    chk("t5_redrain_halted", 32'(halted), 32'h0);
    halt_req = 1'b0;
    wait_run();
    wait_drained();

    // Randomized traffic with halt toggling
    for (int it = 0; it < 150; it++) begin
      logic        we;
      logic [31:0] addr;
      halt_req = ($urandom_range(0, 2) != 0);
      pc = $urandom & 32'h0000_FFFC;
      we = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0001_0000;
      else addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      push(we, addr, $urandom);
      for (int k = $urandom_range(0, 2); k > 0; k--) step();
    end
    halt_req = 1'b1;
    wait_drained();
    halt_req = 1'b0;
    pc = 32'h40;
    wait_run();

    // 6: reset while in DBG with requests queued
    for (int i = 0; i < 4; i++) push(1'b0, 32'h300 + 32'(i) * 4, 32'h0);
    halt_req = 1'b1;
    step();
    step();
    chk("t6_in_dbg", 32'(halted), 32'h1);
    rst = 1'b1;
    halt_req = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("t6_rst_halted", 32'(halted), 32'h0);
    chk("t6_rst_stall", 32'(fetch_stall), 32'h0);
    chk("t6_rst_ready", 32'(dbg_req_ready), 32'h1);
    chk("t6_rst_rsp", 32'(dbg_rsp_valid), 32'h0);
    for (int i = 0; i < 8; i++) step();
    halt_req = 1'b1;
    step();
    step();
    chk("t6_empty_addr", imem_addr, pc);
    chk("t6_empty_we", 32'(imem_we), 32'h0);
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
